// File: rtl/bus_arbiter_if.sv
// Bus bundle for the two-master / one-slave arbiter. The "master" modport is the
// arbiter's view (it masters the slave bus); "slave" is the attached environment.
interface bus_arbiter_if;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_data_i;
  logic        m0_read_i;
  logic        m0_write_i;
  logic [31:0] m0_data_o;
  logic        m0_ack_o;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_data_i;
  logic        m1_read_i;
  logic        m1_write_i;
  logic [31:0] m1_data_o;
  logic        m1_ack_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_data_o;
  logic        s_read_o;
  logic        s_write_o;
  logic [31:0] s_data_i;
  logic        s_ack_i;
  logic        timeout_o;

  modport master (
    input  m0_addr_i, m0_data_i, m0_read_i, m0_write_i,
    input  m1_addr_i, m1_data_i, m1_read_i, m1_write_i,
    input  s_data_i, s_ack_i,
    output m0_data_o, m0_ack_o, m1_data_o, m1_ack_o,
    output s_addr_o, s_data_o, s_read_o, s_write_o, timeout_o
  );

  modport slave (
    output m0_addr_i, m0_data_i, m0_read_i, m0_write_i,
    output m1_addr_i, m1_data_i, m1_read_i, m1_write_i,
    output s_data_i, s_ack_i,
    input  m0_data_o, m0_ack_o, m1_data_o, m1_ack_o,
    input  s_addr_o, s_data_o, s_read_o, s_write_o, timeout_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter: two masters share one slave, one transaction per grant,
// with a watchdog that force-completes transactions the slave never acknowledges.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.master bus
);
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_r;
  logic          owner_r;
  logic          last_grant_r;
  logic [31:0]   addr_r;
  logic [31:0]   data_r;
  logic          read_r;
  logic          write_r;
  logic [CW-1:0] cnt_r;

  logic        req0_s, req1_s, winner_s;
  logic [31:0] win_addr_s, win_data_s;
  logic        win_read_s, win_write_s;
  logic        ack_s, tmo_s, done_s;

  // Request decode and round-robin winner selection
  always_comb begin
    req0_s = bus.m0_read_i | bus.m0_write_i;
    req1_s = bus.m1_read_i | bus.m1_write_i;
    if (req0_s && req1_s) begin
      winner_s = ~last_grant_r;
    end else if (req1_s) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    if (winner_s) begin
      win_addr_s  = bus.m1_addr_i;
      win_data_s  = bus.m1_data_i;
      win_write_s = bus.m1_write_i;
      win_read_s  = bus.m1_read_i & ~bus.m1_write_i;
    end else begin
      win_addr_s  = bus.m0_addr_i;
      win_data_s  = bus.m0_data_i;
      win_write_s = bus.m0_write_i;
      win_read_s  = bus.m0_read_i & ~bus.m0_write_i;
    end
  end

  // Completion: a slave ack always beats a watchdog expiry in the same cycle
  always_comb begin
    ack_s  = (state_r == BUSY) && bus.s_ack_i;
    tmo_s  = (state_r == BUSY) && !bus.s_ack_i && WDOG_EN && (cnt_r == CNT_LAST);
    done_s = ack_s | tmo_s;
  end

  // Master-side return path, same cycle as the slave ack
  always_comb begin
    bus.m0_ack_o  = done_s && (owner_r == 1'b0);
    bus.m1_ack_o  = done_s && (owner_r == 1'b1);
    bus.m0_data_o = (ack_s && (owner_r == 1'b0)) ? bus.s_data_i : 32'h0000_0000;
    bus.m1_data_o = (ack_s && (owner_r == 1'b1)) ? bus.s_data_i : 32'h0000_0000;
    bus.timeout_o = tmo_s;
  end

  assign bus.s_addr_o  = addr_r;
  assign bus.s_data_o  = data_r;
  assign bus.s_read_o  = read_r;
  assign bus.s_write_o = write_r;

  // Grant FSM with latched slave-side command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      addr_r       <= 32'h0000_0000;
      data_r       <= 32'h0000_0000;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      cnt_r        <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req0_s || req1_s) begin
            owner_r      <= winner_s;
            last_grant_r <= winner_s;
            addr_r       <= win_addr_s;
            data_r       <= win_data_s;
            read_r       <= win_read_s;
            write_r      <= win_write_s;
            cnt_r        <= '0;
            state_r      <= BUSY;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r + CW'(1);
          if (done_s) begin
            read_r  <= 1'b0;
            write_r <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          read_r  <= 1'b0;
          write_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table of single-master transactions plus
// hand-written fairness and reset sequences, all completions scored from a queue.
module tb_bus_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] data;
    logic        to;
  } exp_t;

  typedef struct {
    logic        m;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;      // BUSY cycle in which the slave acks, 0 = never
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_to;
    int          exp_cyc;  // cycles with a slave strobe high
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vec[7];
  int   n_pass    = 0;
  int   n_checks  = 0;
  int   ack_count = 0;
  logic prev_ack  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic set_master(input logic m, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
    if (m) begin
      bus.m1_read_i = rd; bus.m1_write_i = wr; bus.m1_addr_i = a; bus.m1_data_i = d;
    end else begin
      bus.m0_read_i = rd; bus.m0_write_i = wr; bus.m0_addr_i = a; bus.m0_data_i = d;
    end
  endtask

  // Completion monitor: pops the scoreboard on every master ack
  always @(negedge clk) begin
    if (bus.m0_ack_o || bus.m1_ack_o) begin
      ack_count++;
      chk("ack_onehot", {31'h0, bus.m0_ack_o & bus.m1_ack_o}, 32'h0);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got m0=%0b m1=%0b, want no ack", bus.m0_ack_o, bus.m1_ack_o);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_master", {31'h0, bus.m1_ack_o}, {31'h0, mon_e.m});
        chk("ack_data", mon_e.m ? bus.m1_data_o : bus.m0_data_o, mon_e.data);
        chk("nonowner_data", mon_e.m ? bus.m0_data_o : bus.m1_data_o, 32'h0);
        chk("timeout_flag", {31'h0, bus.timeout_o}, {31'h0, mon_e.to});
      end
    end else begin
      chk("quiet_data", bus.m0_data_o | bus.m1_data_o, 32'h0);
      chk("quiet_timeout", {31'h0, bus.timeout_o}, 32'h0);
    end
    if (prev_ack) chk("idle_after_done", {30'h0, bus.s_read_o, bus.s_write_o}, 32'h0);
    prev_ack = bus.m0_ack_o | bus.m1_ack_o;
  end

  task automatic run_txn(input vec_t v);
    int cyc  = 0;
    bit done = 1'b0;
    set_master(v.m, v.rd, v.wr, v.addr, v.wdata);
    sb.push_back('{m: v.m, data: v.exp_data, to: v.exp_to});
    for (int k = 1; k <= 20 && !done; k++) begin
      @(posedge clk); #1;
      bus.s_ack_i  = (k == v.lat);
      bus.s_data_i = v.rdata;
      if (k == 1) set_master(v.m, v.rd, v.wr, ~v.addr, ~v.wdata);
      @(negedge clk);
      if (bus.s_read_o || bus.s_write_o) cyc++;
      if (k == 1)
        chk("s_strobes", {30'h0, bus.s_read_o, bus.s_write_o}, {30'h0, v.rd & ~v.wr, v.wr});
      chk("s_addr_held", bus.s_addr_o, v.addr);
      chk("s_data_held", bus.s_data_o, v.wdata);
      done = bus.m0_ack_o | bus.m1_ack_o;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL txn_completion: got no ack in 20 cycles, want ack");
    end
    chk("strobe_cycles", 32'(cyc), 32'(v.exp_cyc));
    @(posedge clk); #1;
    set_master(v.m, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
  endtask

  task automatic wait_acks(input int target, input string name);
    for (int i = 0; i < 40 && ack_count < target; i++) begin
      @(negedge clk); #1;
    end
    chk(name, 32'(ack_count), 32'(target));
  endtask

  initial begin
    vec[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 3};
    vec[1] = '{1'b1, 1'b0, 1'b1, 32'h2000_0004, 32'h1234_5678, 1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1};
    vec[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 0, 32'h1111_2222, 32'h0000_0000, 1'b1, 4};
    vec[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, 4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4};
    vec[4] = '{1'b1, 1'b1, 1'b1, 32'h3000_0000, 32'hA5A5_5A5A, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2};
    vec[5] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h8765_4321, 1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1};
    vec[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 0, 32'h0000_0005, 32'h0000_0000, 1'b1, 4};

    rst_n = 1'b0;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.s_ack_i  = 1'b0;
    bus.s_data_i = 32'h0;

    #12;
    chk("rst_s_addr", bus.s_addr_o, 32'h0);
    chk("rst_s_data", bus.s_data_o, 32'h0);
    chk("rst_strobes", {30'h0, bus.s_read_o, bus.s_write_o}, 32'h0);
    chk("rst_acks", {30'h0, bus.m0_ack_o, bus.m1_ack_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fairness: both masters hold requests, slave acks immediately
    set_master(1'b0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0);
    set_master(1'b1, 1'b1, 1'b0, 32'h0000_0B00, 32'h0);
    bus.s_ack_i  = 1'b1;
    bus.s_data_i = 32'h0000_00F0;
    for (int i = 0; i < 4; i++) sb.push_back('{m: i[0], data: 32'h0000_00F0, to: 1'b0});
    wait_acks(ack_count + 4, "fair_acks");
    @(posedge clk); #1;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vec[i]);

    // Reset in the middle of a transaction the slave is acking
    set_master(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    @(posedge clk); #1;
    bus.s_ack_i  = 1'b1;
    bus.s_data_i = 32'h7777_7777;
    #1;
    chk("pre_reset_ack", {31'h0, bus.m1_ack_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acks", {30'h0, bus.m0_ack_o, bus.m1_ack_o}, 32'h0);
    chk("mid_rst_data", bus.m1_data_o, 32'h0);
    chk("mid_rst_strobes", {30'h0, bus.s_read_o, bus.s_write_o}, 32'h0);
    chk("mid_rst_addr", bus.s_addr_o, 32'h0);
    set_master(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    sb.push_back('{m: 1'b0, data: 32'h7777_7777, to: 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_acks(ack_count + 1, "post_rst_ack");
    @(posedge clk); #1;
    set_master(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_master(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the shared system bus. Sits between the CPU's bus master port (master 0) and a second master (master 1, e.g. DMA or display fetch), and drives the single slave-side bus to memory/peripherals. Grants are round-robin and held for exactly one transaction. A watchdog terminates transactions the slave never acknowledges.

## Interface
- TIMEOUT_CYCLES, 255: cycles in BUSY without s_ack_i before forced termination; 0 disables the watchdog.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_addr_i / m1_addr_i  in  32  master byte address
- m0_data_i / m1_data_i  in  32  master write data
- m0_read_i / m1_read_i  in  1  read request (level, held until ack)
- m0_write_i / m1_write_i  in  1  write request (level, held until ack)
- m0_data_o / m1_data_o  out  32  read data, valid while matching ack is high
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse
- s_addr_o  out  32  slave address
- s_data_o  out  32  slave write data
- s_read_o / s_write_o  out  1  slave strobes, level, held until s_ack_i or timeout
- s_data_i  in  32  slave read data
- s_ack_i  in  1  slave completion
- timeout_o  out  1  one-cycle pulse on watchdog termination

## Operation
- States: IDLE, BUSY. Registers: owner (1 bit), last_grant (1 bit), latched addr/data/cmd, watchdog counter (width clog2(TIMEOUT_CYCLES+1), min 1).
- Request from master n = mn_read_i | mn_write_i. If both read and write asserted, treated as write.
- IDLE: no request -> stay. One requester -> grant it. Both -> grant !last_grant. On grant: owner, last_grant <= winner; latch winner's addr, data, read, write into s_* registers; counter <= 0; -> BUSY.
- BUSY: s_* outputs driven from latched registers (not from live master inputs). Counter increments each cycle.
  - s_ack_i high: mOWNER_ack_o = 1, mOWNER_data_o = s_data_i (combinational, same cycle); s_read_o/s_write_o cleared at edge; -> IDLE.
  - else counter == TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES != 0: mOWNER_ack_o = 1, mOWNER_data_o = 0, timeout_o = 1; strobes cleared; -> IDLE.
  - s_ack_i and timeout in same cycle: ack wins, real data returned, timeout_o stays 0.
- Non-owner ack always 0; m*_data_o = 0 when its ack is 0.
- s_ack_i in IDLE ignored.
- Masters drop request the cycle after ack; the mandatory IDLE cycle guarantees no duplicate grant. Request deasserted while in BUSY is not checked; transaction completes on latched values.

## Timing
- Reset (async assert): state IDLE, owner 0, last_grant 1 (master 0 wins first tie), s_addr_o/s_data_o 0, s_read_o/s_write_o 0, all acks/data_o 0, timeout_o 0, counter 0. Reset mid-BUSY aborts silently, no ack.
- Request sampled at edge E0 (IDLE) -> strobes high in cycle after E0. Earliest ack: that same cycle if slave acks combinationally; min request-to-ack 1 cycle after sampling edge, 2 cycles from an idle start.
- Back-to-back: after completion, 1 IDLE cycle, then next grant; max throughput one transaction per 2 + slave-latency cycles.
- Fairness: with both requesting continuously, grants strictly alternate 0,1,0,1.
- Timeout: ack/timeout_o asserted in the TIMEOUT_CYCLES-th BUSY cycle.

## Test plan
- m0 read 0x0000_1000, slave acks 3 cycles later with 0xCAFE_F00D -> s_read_o high 3 cycles, m0_ack_o one pulse with m0_data_o=0xCAFE_F00D, m1_ack_o 0.
- Both masters request continuously from reset, slave 1-cycle ack -> grant order m0,m1,m0,m1; one IDLE cycle between each.
- m1 write addr 0x2000_0004 data 0x1234_5678 while m0 idle -> s_write_o=1, s_addr_o/s_data_o match; m1_ack_o pulse; changing m1_data_i mid-BUSY does not change s_data_o.
- TIMEOUT_CYCLES=4, slave never acks m0 read -> after 4 BUSY cycles m0_ack_o=1, m0_data_o=0, timeout_o=1, strobes drop, then IDLE.
- s_ack_i on exactly the timeout cycle -> ack with slave data, timeout_o=0.
- rst_n low mid-BUSY -> all outputs 0 immediately; after release both requesting -> m0 granted first.
